// File: rtl/shared_ram_arbiter.sv
// -----------------------------------------------------------------------------
// shared_ram_arbiter
//
// Round-robin arbiter that shares a single data-RAM port among NCORES cores.
// The RAM has a registered read address and async read-out, so read data
// returns one cycle after the grant. That data is routed back to the core
// that issued the read. Only one access reaches the RAM per cycle, so
// conflicting writes are serialised.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   Locked access for atomic read-modify-write. A core that is granted with
//   core_lock=1 keeps the port for up to LOCK_MAX consecutive grants.
//   Without the macro, core_lock is ignored and the arbiter is pure round-robin.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   core_req          per-core request, held until granted
//   core_we           per-core direction (1 = write)
//   core_lock         per-core hold-grant request (ARB_LOCK_EN only)
//   core_addr         packed addresses, core i at [i*AW +: AW]
//   core_wdata        packed write data, core i at [i*DW +: DW]
//   core_gnt          one-hot grant; the access is issued to the RAM this cycle
//   core_rvalid       one-hot; core_rdata is valid for that core
//   core_rdata        shared read-data bus, 0 when no rvalid
//   mem_we, mem_re    RAM write enable / read enable (address register load)
//   mem_addr          RAM address
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module shared_ram_arbiter #(
  parameter int NCORES   = 4,
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    core_req,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES-1:0]    core_lock,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0]    core_gnt,
  output logic [NCORES-1:0]    core_rvalid,
  output logic [DW-1:0]        core_rdata,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NCORES-1:0] rvalid_q, rvalid_d;
  logic [NCORES-1:0] eligible;
  logic [PW-1:0]     win_idx;
  logic              win_found;
  logic              granted;

  // Index following i, wrapping at NCORES-1.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (int'(i) == NCORES - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  // While locked, only the owner may win.
  always_comb begin
    eligible = core_req;
    if (state_q == ST_LOCKED) begin
      eligible          = '0;
      eligible[owner_q] = core_req[owner_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    ptr_d      = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (granted) begin
          ptr_d = next_ptr(win_idx);
          // With LOCK_MAX=1 the first grant is already the last locked one.
          if (core_lock[win_idx] && LOCK_MAX > 1) begin
            state_d    = ST_LOCKED;
            owner_d    = win_idx;
            lock_cnt_d = CW'(1);
          end
        end
      end
      default: begin
        // Owner dropped its request: release, as if its last grant just ended.
        if (!core_req[owner_q]) begin
          state_d    = ST_IDLE;
          ptr_d      = next_ptr(owner_q);
          lock_cnt_d = '0;
        end else if (granted) begin
          if (!core_lock[owner_q] || int'(lock_cnt_q) + 1 >= LOCK_MAX) begin
            state_d    = ST_IDLE;
            ptr_d      = next_ptr(owner_q);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^core_lock;
  assign eligible    = core_req;

  always_comb begin
    ptr_d = ptr_q;
    if (granted) ptr_d = next_ptr(win_idx);
  end
`endif

  // Round-robin scan starting at ptr_q.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Grant and RAM-side strobes are forced low while reset is asserted.
  assign granted = win_found && rst_n;

  always_comb begin
    core_gnt  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rvalid_d  = '0;
    if (granted) begin
      core_gnt[win_idx] = 1'b1;
      mem_addr          = core_addr[win_idx*AW +: AW];
      if (core_we[win_idx]) begin
        mem_we    = 1'b1;
        mem_wdata = core_wdata[win_idx*DW +: DW];
      end else begin
        mem_re            = 1'b1;
        rvalid_d[win_idx] = 1'b1;
      end
    end
  end

  // rvalid_q is one-hot, so it also records which core owns the returning data.
  assign core_rvalid = rvalid_q;
  assign core_rdata  = (|rvalid_q) ? mem_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_ram_arbiter
//
// Directed bench for shared_ram_arbiter with a behavioural RAM (registered read
// address, async read-out). Each stimulus cycle pushes its expected grant and
// RAM strobes. For each read it also pushes the expected return (core, data,
// cycle). A monitor on the falling edge pops these queues and compares them
// against the DUT outputs. Lock scenarios run when ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_shared_ram_arbiter;

  localparam int NC = 4;
  localparam int AW = 9;
  localparam int DW = 16;

  logic              clk;
  logic              rst_n;
  logic [NC-1:0]     core_req, core_we, core_lock;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*DW-1:0]  core_wdata;
  logic [NC-1:0]     core_gnt, core_rvalid;
  logic [DW-1:0]     core_rdata;
  logic              mem_we, mem_re;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  logic [AW-1:0]     addr_a  [NC];
  logic [DW-1:0]     wdata_a [NC];

  shared_ram_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_lock  (core_lock),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    core_addr  = '0;
    core_wdata = '0;
    for (int i = 0; i < NC; i++) begin
      core_addr[i*AW +: AW]  = addr_a[i];
      core_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  // Behavioural RAM.
  logic [DW-1:0] ram [1<<AW];
  logic [AW-1:0] ram_raddr_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) ram_raddr_q   <= mem_addr;
  end
  assign mem_rdata = ram[ram_raddr_q];

  // Expected contents, updated when a write is issued.
  logic [DW-1:0] shadow [1<<AW];

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37 + 16'h0A00);
  endfunction

  typedef struct packed {
    logic [NC-1:0] gnt;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gexp_t;

  typedef struct packed {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } rexp_t;

  gexp_t gnt_q [$];
  rexp_t rd_q  [$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One stimulus cycle. win is the hand-computed winning core (-1: none).
  // With rst_lo set, reset is held low for this cycle and nothing may be granted.
  task automatic step(input logic [NC-1:0] req, input logic [NC-1:0] we,
                      input logic [NC-1:0] lock, input int win, input bit rst_lo = 1'b0);
    gexp_t g;
    rexp_t r;
    @(posedge clk);
    #1;
    core_req  = req;
    core_we   = we;
    core_lock = lock;
    g = '0;
    if (rst_lo) begin
      rst_n = 1'b0;
      // A read return due this cycle is lost to the reset.
      while (rd_q.size() > 0 && rd_q[$].due == cyc) void'(rd_q.pop_back());
    end else begin
      rst_n = 1'b1;
      if (win >= 0) begin
        g.gnt  = NC'(1) << win;
        g.we   = we[win];
        g.re   = !we[win];
        g.addr = addr_a[win];
        if (we[win]) begin
          g.wdata              = wdata_a[win];
          shadow[addr_a[win]]  = wdata_a[win];
        end else begin
          r.core = win;
          r.data = shadow[addr_a[win]];
          r.due  = cyc + 1;
          rd_q.push_back(r);
        end
      end
    end
    gnt_q.push_back(g);
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  gexp_t mg;
  rexp_t mr;
  always @(negedge clk) begin
    if (gnt_q.size() > 0) begin
      mg = gnt_q.pop_front();
      check("gnt",       core_gnt,  mg.gnt);
      check("mem_we",    mem_we,    mg.we);
      check("mem_re",    mem_re,    mg.re);
      check("mem_addr",  mem_addr,  mg.addr);
      check("mem_wdata", mem_wdata, mg.wdata);
    end
    if (core_rvalid != '0 || (rd_q.size() > 0 && rd_q[0].due <= cyc)) begin
      if (rd_q.size() == 0) begin
        check("rvalid_spurious", core_rvalid, 0);
      end else begin
        mr = rd_q.pop_front();
        check("rvalid",       core_rvalid, NC'(1) << mr.core);
        check("rdata",        core_rdata,  mr.data);
        check("rvalid_cycle", cyc,         mr.due);
      end
    end else begin
      check("rdata_idle", core_rdata, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]    = pat(a);
      shadow[a] = pat(a);
    end
    ram_raddr_q = '0;
    for (int i = 0; i < NC; i++) begin
      addr_a[i]  = AW'(16 * i + 3);
      wdata_a[i] = DW'(16'hC000 + i);
    end
    rst_n     = 1'b0;
    core_req  = '0;
    core_we   = '0;
    core_lock = '0;

    // Reset state: outputs forced low even with every core requesting.
    repeat (2) @(posedge clk);
    #1 core_req = 4'b1111;
    @(negedge clk);
    check("rst_gnt",    core_gnt,    0);
    check("rst_mem_re", mem_re,      0);
    check("rst_mem_we", mem_we,      0);
    check("rst_rvalid", core_rvalid, 0);

    // 1: all cores read, ptr=0 -> 0,1,2,3,0.
    step(4'b1111, 4'b0000, 4'b0000, 0);
    step(4'b1111, 4'b0000, 4'b0000, 1);
    step(4'b1111, 4'b0000, 4'b0000, 2);
    step(4'b1111, 4'b0000, 4'b0000, 3);
    step(4'b1111, 4'b0000, 4'b0000, 0);
    step(4'b0000, 4'b0000, 4'b0000, -1);

    // 2: core2 writes 0x1234 @0x05, core1 reads it back the next cycle.
    addr_a[2]  = 9'h005;
    wdata_a[2] = 16'h1234;
    addr_a[1]  = 9'h005;
    step(4'b0100, 4'b0100, 4'b0000, 2);
    step(4'b0010, 4'b0000, 4'b0000, 1);
    step(4'b0000, 4'b0000, 4'b0000, -1);

    // 3: core3 alone for 3 cycles, then ptr has wrapped so core0 beats core3.
    step(4'b1000, 4'b0000, 4'b0000, 3);
    step(4'b1000, 4'b0000, 4'b0000, 3);
    step(4'b1000, 4'b0000, 4'b0000, 3);
    step(4'b1001, 4'b0000, 4'b0000, 0);
    step(4'b0000, 4'b0000, 4'b0000, -1);

    // 4: reset while a read return is pending; after release core0 wins.
    step(4'b0100, 4'b0000, 4'b0000, 2);
    step(4'b1111, 4'b0000, 4'b0000, -1, 1'b1);
    step(4'b1111, 4'b0000, 4'b0000, 0);
    step(4'b0000, 4'b0000, 4'b0000, -1);

`ifdef ARB_LOCK_EN
    // 5: ptr=1. Core1 does a locked read then an unlocked write; core2 follows.
    addr_a[1]  = 9'h040;
    wdata_a[1] = 16'hBEEF;
    step(4'b0111, 4'b0000, 4'b0010, 1);
    step(4'b0111, 4'b0010, 4'b0000, 1);
    step(4'b0101, 4'b0000, 4'b0000, 2);
    step(4'b0000, 4'b0000, 4'b0000, -1);

    // 6: ptr=3 -> grant core3 to bring ptr to 0, then core0 holds lock:
    // 8 consecutive grants, then core1.
    step(4'b1000, 4'b0000, 4'b0000, 3);
    for (int n = 0; n < 8; n++) step(4'b0011, 4'b0000, 4'b0001, 0);
    step(4'b0011, 4'b0000, 4'b0001, 1);
    step(4'b0000, 4'b0000, 4'b0000, -1);
`endif

    step(4'b0000, 4'b0000, 4'b0000, -1);
    step(4'b0000, 4'b0000, 4'b0000, -1);
    @(negedge clk);
    #1;
    check("gnt_queue_drained", gnt_q.size(), 0);
    check("rd_queue_drained",  rd_q.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
